// File: rtl/shmem_arbiter.sv
// Round-robin arbiter granting single-port shared-memory ownership per burst to N_REQ units.
// Optional per-requester grant counters (o_grant_cnt) when SHMEM_ARB_STATS_EN is defined.
module shmem_arbiter #(
  parameter int unsigned N_REQ     = 4,
  parameter int unsigned ADDR_W    = 18,
  parameter int unsigned DATA_W    = 32,
  parameter int unsigned MAX_BURST = 16
) (
  input  logic                       i_clk,
  input  logic                       i_rst,
  input  logic [N_REQ-1:0]           i_req,
  input  logic [N_REQ-1:0]           i_we,
  input  logic [N_REQ-1:0]           i_last,
  input  logic [N_REQ*ADDR_W-1:0]    i_addr,
  input  logic [N_REQ*DATA_W-1:0]    i_wdata,
  output logic [N_REQ-1:0]           o_gnt,
  output logic [N_REQ-1:0]           o_rvalid,
  output logic [DATA_W-1:0]          o_rdata,
  output logic                       o_mem_en,
  output logic                       o_mem_we,
  output logic [ADDR_W-1:0]          o_mem_addr,
  output logic [DATA_W-1:0]          o_mem_wdata,
  input  logic [DATA_W-1:0]          i_mem_rdata,
  output logic                       o_busy
`ifdef SHMEM_ARB_STATS_EN
  ,
  output logic [N_REQ*16-1:0]        o_grant_cnt
`endif
);

  localparam int unsigned PTR_W = $clog2(N_REQ);
  localparam int unsigned CNT_W = $clog2(MAX_BURST + 1);

  typedef enum logic {
    IDLE,
    GRANT
  } state_t;

  state_t           state;
  logic [PTR_W-1:0] rr_ptr;
  logic [PTR_W-1:0] owner;
  logic [PTR_W-1:0] pick;
  logic [PTR_W-1:0] cand;
  logic             found;
  logic [CNT_W-1:0] beat_cnt;
  logic             beat;
  logic             release_now;
  int unsigned      idx;

  assign o_busy  = (state == GRANT);
  assign o_rdata = (|o_rvalid) ? i_mem_rdata : '0;

  // First requester at or after rr_ptr, wrapping explicitly for non-power-of-2 N_REQ.
  always_comb begin
    found = 1'b0;
    pick  = '0;
    idx   = 0;
    cand  = '0;
    for (int unsigned i = 0; i < N_REQ; i++) begin
      idx = rr_ptr + i;
      if (idx >= N_REQ) idx = idx - N_REQ;
      cand = PTR_W'(idx);
      if (!found && i_req[cand]) begin
        found = 1'b1;
        pick  = cand;
      end
    end
  end

  always_comb begin
    beat        = (state == GRANT) && i_req[owner];
    release_now = (state == GRANT) &&
                  (!i_req[owner] || i_last[owner] || (beat_cnt == CNT_W'(MAX_BURST - 1)));
  end

  always_comb begin
    o_mem_en    = 1'b0;
    o_mem_we    = 1'b0;
    o_mem_addr  = '0;
    o_mem_wdata = '0;
    if (state == GRANT) begin
      o_mem_en    = i_req[owner];
      o_mem_we    = i_we[owner];
      o_mem_addr  = i_addr[owner*ADDR_W +: ADDR_W];
      o_mem_wdata = i_wdata[owner*DATA_W +: DATA_W];
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state    <= IDLE;
      o_gnt    <= '0;
      o_rvalid <= '0;
      rr_ptr   <= '0;
      owner    <= '0;
      beat_cnt <= '0;
    end else begin
      o_rvalid <= '0;
      case (state)
        IDLE: begin
          if (found) begin
            state    <= GRANT;
            owner    <= pick;
            o_gnt    <= N_REQ'(1) << pick;
            beat_cnt <= '0;
          end
        end
        GRANT: begin
          if (beat) begin
            beat_cnt <= beat_cnt + 1'b1;
            if (!i_we[owner]) o_rvalid[owner] <= 1'b1;
          end
          if (release_now) begin
            state  <= IDLE;
            o_gnt  <= '0;
            rr_ptr <= (owner == PTR_W'(N_REQ - 1)) ? '0 : owner + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef SHMEM_ARB_STATS_EN
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      o_grant_cnt <= '0;
    end else if ((state == IDLE) && found && (o_grant_cnt[pick*16 +: 16] != 16'hFFFF)) begin
      o_grant_cnt[pick*16 +: 16] <= o_grant_cnt[pick*16 +: 16] + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_shmem_arbiter.sv
// Directed, table-driven bench for shmem_arbiter (4 requesters, MAX_BURST=16).
module tb_shmem_arbiter;

  localparam int unsigned N  = 4;
  localparam int unsigned AW = 18;
  localparam int unsigned DW = 32;

  logic            clk;
  logic            i_rst;
  logic [N-1:0]    i_req, i_we, i_last;
  logic [N*AW-1:0] i_addr;
  logic [N*DW-1:0] i_wdata;
  logic [N-1:0]    o_gnt, o_rvalid;
  logic [DW-1:0]   o_rdata;
  logic            o_mem_en, o_mem_we;
  logic [AW-1:0]   o_mem_addr;
  logic [DW-1:0]   o_mem_wdata;
  logic [DW-1:0]   i_mem_rdata;
  logic            o_busy;
`ifdef SHMEM_ARB_STATS_EN
  logic [N*16-1:0] o_grant_cnt;
`endif

  int n_vec;
  int n_err;

  shmem_arbiter #(
    .N_REQ(4),
    .ADDR_W(18),
    .DATA_W(32),
    .MAX_BURST(16)
  ) dut (
    .i_clk(clk),
    .i_rst(i_rst),
    .i_req(i_req),
    .i_we(i_we),
    .i_last(i_last),
    .i_addr(i_addr),
    .i_wdata(i_wdata),
    .o_gnt(o_gnt),
    .o_rvalid(o_rvalid),
    .o_rdata(o_rdata),
    .o_mem_en(o_mem_en),
    .o_mem_we(o_mem_we),
    .o_mem_addr(o_mem_addr),
    .o_mem_wdata(o_mem_wdata),
    .i_mem_rdata(i_mem_rdata),
    .o_busy(o_busy)
`ifdef SHMEM_ARB_STATS_EN
    ,
    .o_grant_cnt(o_grant_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic          rst;
    logic [3:0]    req, we, last;
    int unsigned   src;
    logic [17:0]   addr;
    logic [31:0]   wdata, mrd;
    logic [3:0]    gnt, rvalid;
    logic [31:0]   rdata;
    logic          en, mwe, busy;
  } vec_t;

  vec_t vecs[$];
  int   rr_end_idx;

  function automatic vec_t mk(logic rst, logic [3:0] req, logic [3:0] we, logic [3:0] last,
                              int unsigned src, logic [17:0] addr, logic [31:0] wdata,
                              logic [31:0] mrd, logic [3:0] gnt, logic [3:0] rvalid,
                              logic [31:0] rdata, logic en, logic mwe, logic busy);
    vec_t v;
    v.rst = rst; v.req = req; v.we = we; v.last = last; v.src = src;
    v.addr = addr; v.wdata = wdata; v.mrd = mrd; v.gnt = gnt; v.rvalid = rvalid;
    v.rdata = rdata; v.en = en; v.mwe = mwe; v.busy = busy;
    return v;
  endfunction

  // Drive one cycle of inputs after the rising edge, check outputs on the falling edge.
  // Non-owner address/data slices carry junk so any leak to the memory port shows.
  task automatic step(string name, vec_t v);
    logic ok;
    logic [17:0] want_addr;
    logic [31:0] want_wdata;
    logic        want_we;
    @(posedge clk);
    #1;
    i_rst       = v.rst;
    i_req       = v.req;
    i_we        = v.we;
    i_last      = v.last;
    i_mem_rdata = v.mrd;
    for (int unsigned k = 0; k < N; k++) begin
      i_addr[k*AW +: AW]  = (k == v.src) ? v.addr  : 18'(32'h3F000 | k);
      i_wdata[k*DW +: DW] = (k == v.src) ? v.wdata : (32'hDEAD0000 | k);
    end
    @(negedge clk);
    want_addr  = v.en ? v.addr  : 18'h0;
    want_wdata = v.en ? v.wdata : 32'h0;
    want_we    = v.en ? v.mwe   : 1'b0;
    ok = (o_gnt == v.gnt) && (o_rvalid == v.rvalid) && (o_mem_en == v.en) && (o_busy == v.busy);
    if (v.rvalid != 4'b0) ok = ok && (o_rdata == v.rdata);
    if (v.en || !v.busy)
      ok = ok && (o_mem_we == want_we) && (o_mem_addr == want_addr) && (o_mem_wdata == want_wdata);
    n_vec++;
    if (!ok) begin
      n_err++;
      $display("FAIL %s: got gnt=%b rvalid=%b rdata=%h en=%b we=%b addr=%h wdata=%h busy=%b; want gnt=%b rvalid=%b rdata=%h en=%b we=%b addr=%h wdata=%h busy=%b",
               name, o_gnt, o_rvalid, o_rdata, o_mem_en, o_mem_we, o_mem_addr, o_mem_wdata, o_busy,
               v.gnt, v.rvalid, v.rdata, v.en, want_we, want_addr, want_wdata, v.busy);
    end
  endtask

`ifdef SHMEM_ARB_STATS_EN
  task automatic check_stats(string name, logic [63:0] want);
    n_vec++;
    if (o_grant_cnt !== want) begin
      n_err++;
      $display("FAIL %s: got grant_cnt=%h want %h", name, o_grant_cnt, want);
    end
  endtask
`endif

  vec_t idle_v;

  initial begin
    n_vec = 0;
    n_err = 0;
    i_rst = 1'b1; i_req = '0; i_we = '0; i_last = '0;
    i_addr = '0; i_wdata = '0; i_mem_rdata = '0;

    // Single requester: req0 writes 4 beats 0x100..0x103 / 0xA0..0xA3.
    vecs.push_back(mk(0, 4'b0001, 4'b0001, 4'b0000, 0, 18'h100, 32'hA0, 0, 4'b0000, 0, 0, 0, 0, 0));
    for (int j = 0; j < 4; j++)
      vecs.push_back(mk(0, 4'b0001, 4'b0001, (j == 3) ? 4'b0001 : 4'b0000, 0,
                        18'(32'h100 + j), 32'hA0 + j, 0, 4'b0001, 0, 0, 1, 1, 1));
    vecs.push_back(mk(0, 4'b0000, 4'b0000, 4'b0000, 0, 0, 0, 0, 4'b0000, 0, 0, 0, 0, 0));

    // Reset, then round-robin with all four requesting single-beat writes.
    vecs.push_back(mk(1, 4'b0000, 4'b0000, 4'b0000, 0, 0, 0, 0, 4'b0000, 0, 0, 0, 0, 0));
    for (int j = 0; j < 5; j++) begin
      vecs.push_back(mk(0, 4'b1111, 4'b1111, 4'b1111, 0, 0, 0, 0, 4'b0000, 0, 0, 0, 0, 0));
      vecs.push_back(mk(0, 4'b1111, 4'b1111, 4'b1111, j % 4, 18'(32'h200 + j), 32'hB0 + j, 0,
                        4'(1 << (j % 4)), 0, 0, 1, 1, 1));
    end
    vecs.push_back(mk(0, 4'b0000, 4'b0000, 4'b0000, 0, 0, 0, 0, 4'b0000, 0, 0, 0, 0, 0));
    rr_end_idx = vecs.size() - 1;

    // Burst limit: req1 streams 20 beats, req2 waits with a single-beat burst.
    vecs.push_back(mk(0, 4'b0110, 4'b0110, 4'b0100, 1, 18'h300, 32'hC00, 0, 4'b0000, 0, 0, 0, 0, 0));
    for (int j = 0; j < 16; j++)
      vecs.push_back(mk(0, 4'b0110, 4'b0110, 4'b0100, 1, 18'(32'h300 + j), 32'hC00 + j, 0,
                        4'b0010, 0, 0, 1, 1, 1));
    vecs.push_back(mk(0, 4'b0110, 4'b0110, 4'b0100, 2, 18'h3F0, 32'hCC, 0, 4'b0000, 0, 0, 0, 0, 0));
    vecs.push_back(mk(0, 4'b0110, 4'b0110, 4'b0100, 2, 18'h3F0, 32'hCC, 0, 4'b0100, 0, 0, 1, 1, 1));
    vecs.push_back(mk(0, 4'b0010, 4'b0010, 4'b0000, 1, 18'h310, 32'hC10, 0, 4'b0000, 0, 0, 0, 0, 0));
    for (int j = 16; j < 20; j++)
      vecs.push_back(mk(0, 4'b0010, 4'b0010, (j == 19) ? 4'b0010 : 4'b0000, 1,
                        18'(32'h300 + j), 32'hC00 + j, 0, 4'b0010, 0, 0, 1, 1, 1));
    vecs.push_back(mk(0, 4'b0000, 4'b0000, 4'b0000, 0, 0, 0, 0, 4'b0000, 0, 0, 0, 0, 0));

    // Read pipeline: req2 reads 0x10, 0x11; memory returns 0x55 then 0x66.
    vecs.push_back(mk(0, 4'b0100, 4'b0000, 4'b0000, 2, 18'h10, 0, 32'hBAD, 4'b0000, 0, 0, 0, 0, 0));
    vecs.push_back(mk(0, 4'b0100, 4'b0000, 4'b0000, 2, 18'h10, 0, 32'hBAD, 4'b0100, 0, 0, 1, 0, 1));
    vecs.push_back(mk(0, 4'b0100, 4'b0000, 4'b0100, 2, 18'h11, 0, 32'h55, 4'b0100, 4'b0100, 32'h55, 1, 0, 1));
    vecs.push_back(mk(0, 4'b0000, 4'b0000, 4'b0000, 0, 0, 0, 32'h66, 4'b0000, 4'b0100, 32'h66, 0, 0, 0));
    vecs.push_back(mk(0, 4'b0000, 4'b0000, 4'b0000, 0, 0, 0, 32'h99, 4'b0000, 4'b0000, 0, 0, 0, 0));

    // Reset check.
    step("reset", mk(1, 4'b0000, 4'b0000, 4'b0000, 0, 0, 0, 0, 4'b0000, 0, 0, 0, 0, 0));

    for (int i = 0; i < vecs.size(); i++) begin
      step($sformatf("vec%0d", i), vecs[i]);
`ifdef SHMEM_ARB_STATS_EN
      if (i == rr_end_idx) check_stats("stats_rr", {16'd1, 16'd1, 16'd1, 16'd2});
`endif
    end

    // Reset mid-burst: rr_ptr is 3 here, so without reset req3 would win the next arbitration.
    step("rst_e0", mk(0, 4'b1000, 4'b0000, 4'b0000, 3, 18'h20, 0, 0, 4'b0000, 0, 0, 0, 0, 0));
    step("rst_e1", mk(0, 4'b1000, 4'b0000, 4'b0000, 3, 18'h20, 0, 0, 4'b1000, 0, 0, 1, 0, 1));
    step("rst_e2", mk(1, 4'b1000, 4'b0000, 4'b0000, 3, 18'h21, 0, 32'h77, 4'b1000, 4'b1000, 32'h77, 1, 0, 1));
    step("rst_e3", mk(0, 4'b1001, 4'b0000, 4'b0000, 0, 18'h30, 0, 32'h12, 4'b0000, 0, 0, 0, 0, 0));
    step("rst_e4", mk(0, 4'b1001, 4'b0000, 4'b0001, 0, 18'h30, 0, 32'h12, 4'b0001, 0, 0, 1, 0, 1));
    step("rst_e5", mk(0, 4'b0000, 4'b0000, 4'b0000, 0, 0, 0, 32'h88, 4'b0000, 4'b0001, 32'h88, 0, 0, 0));

    // Request drop releases ownership and advances rr_ptr past the dropped owner.
    step("drop_f0", mk(0, 4'b0001, 4'b0001, 4'b0000, 0, 18'h40, 32'hF0, 0, 4'b0000, 0, 0, 0, 0, 0));
    step("drop_f1", mk(0, 4'b0000, 4'b0000, 4'b0000, 0, 18'h40, 32'hF0, 0, 4'b0001, 0, 0, 0, 0, 1));
    step("drop_f2", mk(0, 4'b0011, 4'b0011, 4'b0010, 1, 18'h41, 32'hF1, 0, 4'b0000, 0, 0, 0, 0, 0));
    step("drop_f3", mk(0, 4'b0011, 4'b0011, 4'b0010, 1, 18'h41, 32'hF1, 0, 4'b0010, 0, 0, 1, 1, 1));
    step("drop_f4", mk(0, 4'b0000, 4'b0000, 4'b0000, 0, 0, 0, 0, 4'b0000, 0, 0, 0, 0, 0));
`ifdef SHMEM_ARB_STATS_EN
    check_stats("stats_end", {16'd0, 16'd0, 16'd1, 16'd2});
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/shmem_arbiter.md
# shmem_arbiter

Round-robin arbiter that shares the single-port shared memory between `N_REQ` processing units of the pool. It sits between the pool's per-unit memory ports and the shared memory. Each unit owns the memory for one burst of read or write beats. The arbiter releases ownership on last beat, on request drop, or when the burst limit is reached, so that no unit can starve the others during a matvec/recomposition task.

## Interface
Parameters:
- `N_REQ`, 4: number of requesters (≥2).
- `ADDR_W`, 18: shared-memory word address width.
- `DATA_W`, 32: shared-memory word width.
- `MAX_BURST`, 16: maximum beats per grant before forced release (≥1).

Ports:
- `i_clk`, input, 1: clock; all logic is on the rising edge.
- `i_rst`, input, 1: synchronous, active-high reset.
- `i_req`, input, N_REQ: per-requester request/beat-valid.
- `i_we`, input, N_REQ: per-requester write enable for the current beat.
- `i_last`, input, N_REQ: marks the requester's final beat of a burst.
- `i_addr`, input, N_REQ*ADDR_W: packed addresses; requester k is at `[k*ADDR_W +: ADDR_W]`.
- `i_wdata`, input, N_REQ*DATA_W: packed write data, same packing.
- `o_gnt`, output, N_REQ: registered one-hot ownership grant.
- `o_rvalid`, output, N_REQ: one-hot read-data-valid.
- `o_rdata`, output, DATA_W: read data, broadcast to all requesters.
- `o_mem_en`, output, 1: memory access strobe.
- `o_mem_we`, output, 1: memory write enable.
- `o_mem_addr`, output, ADDR_W: memory address.
- `o_mem_wdata`, output, DATA_W: memory write data.
- `i_mem_rdata`, input, DATA_W: memory read data, valid 1 cycle after a read strobe.
- `o_busy`, output, 1: high while the arbiter is in GRANT.

## Operation
- State machine:
  - IDLE: if any `i_req` is set, select the first set bit at or after `rr_ptr`, wrapping modulo N_REQ. Load the one-hot `o_gnt`, clear `beat_cnt`, and go to GRANT. Otherwise stay in IDLE.
  - GRANT: owner k. A beat occurs on a cycle with `o_gnt[k] && i_req[k]`.
    - The memory port is driven combinationally from requester k: `o_mem_en = i_req[k]`, `o_mem_we = i_we[k]`, plus k's addr/wdata slice.
    - Each beat increments `beat_cnt`.
  - Release to IDLE on any of:
    - a beat with `i_last[k]`;
    - `i_req[k]==0` (no beat that cycle);
    - a beat with `beat_cnt==MAX_BURST-1`.
  - On release: `o_gnt` is cleared and `rr_ptr = (k+1) mod N_REQ`.
- Requests from non-owners are ignored in GRANT. Their `i_we`/`i_addr`/`i_last` never reach the memory.
- Read return: a beat with `i_we[k]==0` sets `o_rvalid[k]` on the next cycle, with `o_rdata = i_mem_rdata` in that cycle. Read beats may be back-to-back, giving one rvalid per beat in order.
- `o_mem_en`, `o_mem_we`, `o_mem_addr` and `o_mem_wdata` are 0 in IDLE.
- `beat_cnt` width is `$clog2(MAX_BURST+1)`. `rr_ptr` width is `$clog2(N_REQ)`. Wrap is explicit, so non-power-of-2 `N_REQ` is supported.

## Timing
- Reset values: `o_gnt=0`, `o_rvalid=0`, `o_busy=0`, all memory outputs 0, state=IDLE, `rr_ptr=0`, `beat_cnt=0`.
- Arbitration latency: request in IDLE at cycle t gives `o_gnt` at t+1. The first beat can occur at t+1.
- Release bubble: after a release at cycle t, the arbiter is in IDLE at t+1 and the next owner's grant appears at t+2. There is one dead cycle per handover.
- Read latency: beat at t gives `o_rvalid`/`o_rdata` at t+1. The rvalid of a beat that triggered release still fires.
- Simultaneous requests in IDLE: the round-robin order from `rr_ptr` decides. A grant never goes to a requester with `i_req` low.
- Reset mid-burst (`i_rst` high at a rising edge): all outputs take their reset values at that edge. An in-flight read's rvalid is suppressed.

## Configuration
- `SHMEM_ARB_STATS_EN`
  - Defined: adds output `o_grant_cnt`, N_REQ*16 bits, packed per requester. Each field counts grants (IDLE→GRANT entries) for that requester and saturates at 16'hFFFF. Fields are cleared by `i_rst`.
  - Undefined: the port and the counters are absent. All other behaviour is identical.

## Test plan
- Single requester: after reset, req0 writes a 4-beat burst to addr 0x100..0x103 with data 0xA0..0xA3, `i_last` on the 4th beat. Expect:
  - `o_gnt=4'b0001` one cycle after req;
  - 4 memory writes with matching addr/data;
  - `o_gnt=0` after the last beat.
- Round-robin: req0..req3 all held high, single-beat bursts with `i_last`. Expect grant order 0,1,2,3,0 with one idle cycle between grants.
- Burst limit: `MAX_BURST=16`, req1 streams 20 beats without `i_last` while req2 waits. Expect forced release after beat 16, then req2 granted; req1 is regranted afterwards.
- Read pipeline: req2 issues back-to-back reads at 0x10 and 0x11, memory returning 0x55 and 0x66. Expect `o_rvalid[2]` on the two following cycles with `o_rdata` 0x55 then 0x66.
- Reset mid-burst: assert `i_rst` during req3's second read beat. Expect `o_gnt`, `o_rvalid` and `o_busy` all 0 next cycle, and `rr_ptr` back at 0, so req0 wins over req3 when both then request.
- With `SHMEM_ARB_STATS_EN`: after the round-robin scenario, `o_grant_cnt` shows 2 for requester 0 and 1 for requesters 1–3.
